// File: rtl/regfile_wr_sched.sv
// Write scheduler in front of the 3R/1W register-file RAM: merges two commit
// write ports through an in-order buffer, forwards buffered data to reads and zero-sweeps the RAM after reset.
module regfile_wr_sched #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w0_valid,
  input  logic [4:0]         w0_addr,
  input  logic [WIDTH-1:0]   w0_data,
  output logic               w0_ready,
  input  logic               w1_valid,
  input  logic [4:0]         w1_addr,
  input  logic [WIDTH-1:0]   w1_data,
  output logic               w1_ready,
  input  logic [14:0]        r_addr,
  output logic [3*WIDTH-1:0] r_data,
  output logic               init_done,
  output logic [4:0]         ram_addr0,
  output logic [4:0]         ram_addr1,
  output logic [4:0]         ram_addr2,
  input  logic [WIDTH-1:0]   ram_dout0,
  input  logic [WIDTH-1:0]   ram_dout1,
  input  logic [WIDTH-1:0]   ram_dout2,
  output logic [4:0]         ram_addrw,
  output logic [WIDTH-1:0]   ram_din,
  output logic               ram_we
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_q, state_d;
  logic [4:0]         sweep_q, sweep_d;
  logic [4:0]         buf_addr_q [DEPTH];
  logic [4:0]         buf_addr_d [DEPTH];
  logic [WIDTH-1:0]   buf_data_q [DEPTH];
  logic [WIDTH-1:0]   buf_data_d [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2:0]         hit_q, hit_d;
  logic [2:0]         zero_q, zero_d;
  logic [WIDTH-1:0]   fwd_q [3];
  logic [WIDTH-1:0]   fwd_d [3];

  logic [CW-1:0]      free;
  logic               enq0, enq1, pop;
  logic [WIDTH-1:0]   ram_dout [3];

  assign init_done = (state_q == RUN);

  // Free space comes from the registered count only; a same-cycle drain is not credited.
  assign free     = CW'(DEPTH) - count_q;
  assign w0_ready = init_done & (free >= CW'(1));
  assign w1_ready = init_done & ((free >= CW'(2)) | ((free >= CW'(1)) & ~w0_valid));

  assign enq0 = w0_valid & w0_ready & (w0_addr != 5'd0);
  assign enq1 = w1_valid & w1_ready & (w1_addr != 5'd0);
  assign pop  = init_done & (count_q != '0);

  assign ram_addr0 = r_addr[4:0];
  assign ram_addr1 = r_addr[9:5];
  assign ram_addr2 = r_addr[14:10];
  assign ram_dout[0] = ram_dout0;
  assign ram_dout[1] = ram_dout1;
  assign ram_dout[2] = ram_dout2;

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    ram_we    = 1'b0;
    ram_addrw = buf_addr_q[rd_ptr_q];
    ram_din   = buf_data_q[rd_ptr_q];
    case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_addrw = sweep_q;
        ram_din   = '0;
        sweep_d   = sweep_q + 5'd1;
        if (sweep_q == 5'd31) state_d = RUN;
      end
      RUN: begin
        ram_we = pop;
      end
      default: state_d = INIT;
    endcase
  end

  // When both ports enqueue, w0 takes the tail slot first so it drains ahead of w1.
  always_comb begin
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    if (enq0) begin
      buf_addr_d[wr_ptr_q] = w0_addr;
      buf_data_d[wr_ptr_q] = w0_data;
    end
    if (enq1) begin
      buf_addr_d[wr_ptr_q + PW'(enq0)] = w1_addr;
      buf_data_d[wr_ptr_q + PW'(enq0)] = w1_data;
    end
    wr_ptr_d = wr_ptr_q + PW'(enq0) + PW'(enq1);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(enq0) + CW'(enq1) - CW'(pop);
  end

  // Scan oldest to newest so the youngest matching entry overrides earlier ones.
  always_comb begin
    logic [4:0]    raddr;
    logic [PW-1:0] idx;
    raddr  = '0;
    idx    = '0;
    hit_d  = '0;
    zero_d = '0;
    fwd_d  = '{default: '0};
    for (int k = 0; k < 3; k++) begin
      raddr     = r_addr[5*k +: 5];
      zero_d[k] = (raddr == 5'd0);
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PW'(i);
        if ((CW'(i) < count_q) && (buf_addr_q[idx] == raddr)) begin
          hit_d[k] = 1'b1;
          fwd_d[k] = buf_data_q[idx];
        end
      end
    end
  end

  always_comb begin
    r_data = '0;
    if (init_done) begin
      for (int k = 0; k < 3; k++) begin
        if (zero_q[k])     r_data[WIDTH*k +: WIDTH] = '0;
        else if (hit_q[k]) r_data[WIDTH*k +: WIDTH] = fwd_q[k];
        else               r_data[WIDTH*k +: WIDTH] = ram_dout[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      sweep_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      hit_q    <= '0;
      zero_q   <= '0;
      for (int k = 0; k < 3; k++) fwd_q[k] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      hit_q      <= hit_d;
      zero_q     <= zero_d;
      fwd_q      <= fwd_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Bench for regfile_wr_sched: behavioural RAM, architected-state model, and
// queues of expected RAM writes and read results.
module tb_regfile_wr_sched;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               w0_valid = 1'b0, w1_valid = 1'b0;
  logic [4:0]         w0_addr = '0, w1_addr = '0;
  logic [WIDTH-1:0]   w0_data = '0, w1_data = '0;
  logic               w0_ready, w1_ready;
  logic [14:0]        r_addr = '0;
  logic [3*WIDTH-1:0] r_data;
  logic               init_done;
  logic [4:0]         ram_addr0, ram_addr1, ram_addr2, ram_addrw;
  logic [WIDTH-1:0]   ram_dout0, ram_dout1, ram_dout2, ram_din;
  logic               ram_we;

  always #5 clk = ~clk;

  regfile_wr_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .w0_valid(w0_valid), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ready(w0_ready),
    .w1_valid(w1_valid), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ready(w1_ready),
    .r_addr(r_addr), .r_data(r_data), .init_done(init_done),
    .ram_addr0(ram_addr0), .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
    .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2),
    .ram_addrw(ram_addrw), .ram_din(ram_din), .ram_we(ram_we)
  );

  // Registered-read RAM; a read in the same cycle as a write returns the old value.
  logic [WIDTH-1:0] ram_mem [32];
  logic             poke_en = 1'b0;
  logic [4:0]       poke_addr = '0;
  logic [WIDTH-1:0] poke_data = '0;

  always @(posedge clk) begin
    ram_dout0 <= ram_mem[ram_addr0];
    ram_dout1 <= ram_mem[ram_addr1];
    ram_dout2 <= ram_mem[ram_addr2];
    if (poke_en)     ram_mem[poke_addr] <= poke_data;
    else if (ram_we) ram_mem[ram_addrw] <= ram_din;
  end

  typedef struct {
    logic [4:0]       addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  typedef struct {
    int           issue;
    logic [95:0]  exp;
  } rd_t;

  typedef struct {
    logic        w0v;
    logic [4:0]  w0a;
    logic [31:0] w0d;
    logic        w1v;
    logic [4:0]  w1a;
    logic [31:0] w1d;
    logic        rd;
    logic [14:0] ra;
    logic        exp_r0;
    logic        exp_r1;
  } vec_t;

  wr_t         wr_q[$];
  rd_t         rd_q[$];
  logic [31:0] arch [32];
  int          cyc = 0;
  logic        mon_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  vec_t        tbl [10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Every RAM write must match the next expected one; no write when none is owed.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      checkOutput("ram_we", 96'(ram_we), 96'(wr_q.size() != 0));
      if (ram_we && wr_q.size() != 0) begin
        wr_t w;
        w = wr_q.pop_front();
        checkOutput("ram_write", {ram_addrw, ram_din}, {w.addr, w.data});
      end
      if (rd_q.size() != 0 && rd_q[0].issue == cyc - 1) begin
        rd_t r;
        r = rd_q.pop_front();
        checkOutput("read_data", r_data, r.exp);
      end
    end
  end

  function automatic logic [95:0] expRead(input logic [14:0] ra);
    logic [95:0] res;
    logic [4:0]  a;
    res = '0;
    for (int k = 0; k < 3; k++) begin
      a = ra[5*k +: 5];
      res[32*k +: 32] = (a == 5'd0) ? 32'd0 : arch[a];
    end
    return res;
  endfunction

  function automatic vec_t idleVec(input logic rd, input logic [14:0] ra);
    return '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rd, ra, 1'b1, 1'b1};
  endfunction

  task automatic applyStimulus(input vec_t v);
    w0_valid = v.w0v;
    w0_addr  = v.w0a;
    w0_data  = v.w0d;
    w1_valid = v.w1v;
    w1_addr  = v.w1a;
    w1_data  = v.w1d;
    r_addr   = v.ra;
  endtask

  // One cycle: drive at posedge+1, check and book-keep after the negedge.
  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(negedge clk); #1;
    checkOutput("w0_ready", 96'(w0_ready), 96'(v.exp_r0));
    checkOutput("w1_ready", 96'(w1_ready), 96'(v.exp_r1));
    if (v.rd) rd_q.push_back('{cyc, expRead(v.ra)});
    if (v.w0v && v.exp_r0 && v.w0a != 5'd0) begin
      wr_q.push_back('{v.w0a, v.w0d});
      arch[v.w0a] = v.w0d;
    end
    if (v.w1v && v.exp_r1 && v.w1a != 5'd0) begin
      wr_q.push_back('{v.w1a, v.w1d});
      arch[v.w1a] = v.w1d;
    end
    @(posedge clk); #1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_init_done", 96'(init_done), 96'(0));
    checkOutput("rst_ram_we", 96'(ram_we), 96'(1));
    checkOutput("rst_ram_addrw", 96'(ram_addrw), 96'(0));
    checkOutput("rst_ram_din", 96'(ram_din), 96'(0));
    checkOutput("rst_r_data", r_data, 96'(0));
    checkOutput("rst_ready", {94'(0), w0_ready, w1_ready}, 96'(0));
  endtask

  // Called with rst_n low; releases it and follows the 32-cycle zero sweep.
  task automatic doInit();
    applyStimulus(idleVec(1'b0, {5'd9, 5'd5, 5'd1}));
    for (int a = 0; a < 32; a++) wr_q.push_back('{5'(a), 32'd0});
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); #1;
      checkOutput("init_done_low", 96'(init_done), 96'(0));
      checkOutput("init_ready", {94'(0), w0_ready, w1_ready}, 96'(0));
      checkOutput("init_r_data", r_data, 96'(0));
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    checkOutput("init_done_high", 96'(init_done), 96'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    for (int a = 0; a < 32; a++) arch[a] = '0;

    tbl[0] = '{1'b1, 5'd1, 32'h0101_0001, 1'b1, 5'd2, 32'h0202_0002, 1'b0, 15'd0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 5'd3, 32'h0303_0003, 1'b1, 5'd4, 32'h0404_0004, 1'b0, 15'd0, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 5'd5, 32'h0505_0005, 1'b1, 5'd6, 32'h0606_0006, 1'b0, 15'd0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 5'd6, 32'h0606_0006, 1'b1, 5'd7, 32'h0707_0007, 1'b0, 15'd0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0707_0007, 1'b0, 15'd0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, {5'd3, 5'd2, 5'd1}, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, {5'd7, 5'd6, 5'd5}, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd8, 32'h0808_0008, 1'b0, 15'd0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, {5'd0, 5'd0, 5'd0}, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, {5'd1, 5'd0, 5'd8}, 1'b1, 1'b1};

    // Reset values, then the zero sweep.
    repeat (2) @(posedge clk);
    #2;
    checkResetValues();
    doInit();

    // Same-address pair: bypass while buffered, then RAM after drain.
    runVec('{1'b1, 5'd5, 32'hAAAA_0000, 1'b1, 5'd5, 32'h5555_FFFF, 1'b0, 15'd0, 1'b1, 1'b1});
    for (int i = 0; i < 4; i++) runVec(idleVec(1'b1, {5'd0, 5'd0, 5'd5}));
    runVec(idleVec(1'b0, 15'd0));

    // Plant RAM garbage at reg 0 and reg 20 while the buffer is idle.
    poke_en = 1'b1; poke_addr = 5'd0; poke_data = 32'hDEAD_BEEF;
    runVec(idleVec(1'b0, 15'd0));
    poke_addr = 5'd20; poke_data = 32'hBAD0_0020;
    runVec(idleVec(1'b0, 15'd0));
    poke_en = 1'b0;

    // Fill to the back-pressure point, reg-0 write, reads along the way.
    for (int i = 0; i < 10; i++) runVec(tbl[i]);
    for (int i = 0; i < 3; i++) runVec(idleVec(1'b1, {5'd0, 5'd0, 5'd0}));

    // Ports 0/1 hit a buffered entry, port 2 comes from RAM.
    runVec('{1'b1, 5'd7, 32'h7777_0007, 1'b0, 5'd0, 32'h0, 1'b0, 15'd0, 1'b1, 1'b1});
    runVec(idleVec(1'b0, 15'd0));
    runVec(idleVec(1'b0, 15'd0));
    runVec('{1'b1, 5'd9, 32'h9999_0009, 1'b1, 5'd3, 32'h3333_CAFE, 1'b0, 15'd0, 1'b1, 1'b1});
    runVec(idleVec(1'b1, {5'd7, 5'd3, 5'd3}));
    for (int i = 0; i < 3; i++) runVec(idleVec(1'b1, {5'd7, 5'd9, 5'd3}));

    // Reset with three entries still buffered.
    runVec('{1'b1, 5'd11, 32'hB0B0_0011, 1'b1, 5'd12, 32'hB0B0_0012, 1'b0, 15'd0, 1'b1, 1'b1});
    runVec('{1'b1, 5'd13, 32'hB0B0_0013, 1'b1, 5'd14, 32'hB0B0_0014, 1'b0, 15'd0, 1'b1, 1'b1});
    w0_valid = 1'b1; w1_valid = 1'b1; r_addr = {5'd13, 5'd12, 5'd11};
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    checkResetValues();
    wr_q.delete();
    rd_q.delete();
    for (int a = 0; a < 32; a++) arch[a] = '0;
    repeat (2) @(posedge clk);
    #1;
    doInit();
    runVec(idleVec(1'b1, {5'd14, 5'd13, 5'd12}));
    runVec(idleVec(1'b1, {5'd20, 5'd11, 5'd0}));
    for (int i = 0; i < 3; i++) runVec(idleVec(1'b0, 15'd0));

    checkOutput("wr_queue_empty", 96'(wr_q.size()), 96'(0));
    checkOutput("rd_queue_empty", 96'(rd_q.size()), 96'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
- Front-end controller for the 32-entry, 3-read/1-write register-file RAM.
- Merges two commit write ports into the RAM's single write port through a small in-order write buffer.
- Forwards buffered (not yet written) data to the three read ports.
- After every reset, sweeps all 32 entries to zero, because the RAM macros have no reset.

Parameters:
WIDTH, 32, data width of each register entry
DEPTH, 4, write-buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
w0_valid  in  1  commit write 0 request (older in program order)
w0_addr  in  5  commit write 0 register index
w0_data  in  WIDTH  commit write 0 data
w0_ready  out  1  commit write 0 accepted when valid&ready
w1_valid  in  1  commit write 1 request (younger)
w1_addr  in  5  commit write 1 register index
w1_data  in  WIDTH  commit write 1 data
w1_ready  out  1  commit write 1 accepted when valid&ready
r_addr  in  15  three read indices, port k at [5k+4:5k]
r_data  out  3*WIDTH  three read results, port k at [WIDTH*k+WIDTH-1:WIDTH*k]
init_done  out  1  high once the zero sweep has completed
ram_addr0/1/2  out  5 each  RAM read addresses (= r_addr fields, pass-through)
ram_dout0/1/2  in  WIDTH each  RAM read data, registered, valid 1 cycle after address
ram_addrw  out  5  RAM write address
ram_din  out  WIDTH  RAM write data
ram_we  out  1  RAM write enable

Behaviour:
- Reset: asynchronous, active-low, on rst_n; all state is clocked on clk.
- FSM states: INIT and RUN. Reset enters INIT with sweep counter = 0 and the buffer empty.
- INIT:
  - ram_we=1, ram_addrw=counter, ram_din=0; counter increments each cycle.
  - After the write of address 31, move to RUN; init_done goes to 1 in the first RUN cycle.
  - Held during INIT: w0_ready=w1_ready=0 and r_data=0.
- Output reset values: init_done=0, ram_we=1, ram_addrw=0, ram_din=0, r_data=0, w*_ready=0.
- RUN never returns to INIT except through reset.
- Buffer:
  - FIFO of {addr,data}; free = DEPTH - count, taken from registered count (a drain in the same cycle is not credited).
  - w0_ready = init_done & (free>=1).
  - w1_ready = init_done & (free>=2 | (free>=1 & !w0_valid)).
- Acceptance order: when both ports are accepted, w0 is enqueued ahead of w1.
- Register 0: writes with addr==0 are accepted (ready as above) but not enqueued and do not consume free slots.
- Drain in RUN:
  - When count>0: ram_we=1, ram_addrw/ram_din = head entry, and the head pops at the clock edge.
  - When count==0: ram_we=0.
  - At most one drain per cycle; enqueue and drain may happen in the same cycle.
- Read timing: r_addr sampled in cycle t, r_data valid in cycle t+1.
  - r_data reflects every write accepted in cycles < t; writes accepted in cycle t are not visible to reads issued in t.
- Bypass:
  - In cycle t, each read port compares its address against all valid buffer entries, including the head being drained in t.
  - The newest matching entry wins; its data is registered and muxed onto r_data at t+1.
  - No match: r_data = ram_doutk.
  - r_addr==0: r_data=0 regardless of RAM contents.
- Duplicate addresses in the buffer: drained in FIFO order, so the RAM ends holding the youngest value.
- Reset mid-operation (sweep or drain): buffered writes are discarded and the sweep restarts from 0.

Test Plan:
1. Release reset; hold w*_valid=0 -> ram_we=1 for exactly 32 cycles with addrw 0..31 and din=0; init_done=1 on cycle 33; no ready asserted before that.
2. After init, same cycle: w0(addr 5, 0xAAAA0000) and w1(addr 5, 0x5555FFFF) -> both accepted; RAM written 0xAAAA0000 then 0x5555FFFF; a read of 5 issued the next cycle returns 0x5555FFFF via bypass; a read after drain returns it from RAM.
3. Hold w0_valid=1 with distinct addresses and stall the RAM view by filling the buffer (DEPTH=4) -> w1_ready drops when free<2 while w0_valid=1; no entry lost; drain order matches acceptance order.
4. w0 writes addr 0 with 0x12345678 -> accepted, no RAM write; all three ports reading addr 0 return 0.
5. Three read ports addressing 3, 3, 7 while addr 3 is buffered and addr 7 is in RAM -> ports 0/1 get the buffered value, port 2 gets the RAM value, all one cycle later.
6. Assert rst_n=0 with 3 entries buffered mid-drain -> outputs return to reset values; after release the sweep restarts at address 0 and the buffered entries are never written.
